// File: rtl/ktc16_pkg.sv
// Shared definitions for the ktc16 console block: register map, STATUS bit
// positions and the serial transmitter state encoding.
package ktc16_pkg;

  // Register byte offsets from the console base address
  localparam logic [15:0] CON_DATA   = 16'd0;
  localparam logic [15:0] CON_EXIT   = 16'd4;
  localparam logic [15:0] CON_STATUS = 16'd8;

  // STATUS register bit positions
  localparam int ST_DONE      = 0;
  localparam int ST_PASS      = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_EMPTY     = 3;
  localparam int ST_FULL      = 4;
  localparam int ST_OVERFLOW  = 5;
  localparam int ST_COUNT_LSB = 8;

  // Write-one-to-clear bit for overflow in a STATUS store
  localparam int ST_CLR_OVF   = 5;

  // Serial transmitter states
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } con_tx_state_t;

endpackage

// File: rtl/ktc16_console_sync_fifo.sv
// Small synchronous FIFO. A push while full and a pop while empty are
// ignored; fullness is judged on the pre-edge count, so a push into a full
// FIFO is rejected even if a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == (AW+1)'(0));
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage array; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy; reset flushes the queue
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ktc16_console.sv
// Memory-mapped console: DATA stores queue characters for an 8N1 serial
// transmitter, EXIT latches the program's result code, STATUS reports
// progress. Reads are combinational so the top level can mux them like ram.
module ktc16_console
  import ktc16_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'd80,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] PASS_CODE    = 16'd7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [15:0] addr,
  input  logic [15:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic        tx,
  output logic        done,
  output logic        pass
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
  localparam logic [15:0]   ADDR_DATA = BASE_ADDR + CON_DATA;
  localparam logic [15:0]   ADDR_EXIT = BASE_ADDR + CON_EXIT;
  localparam logic [15:0]   ADDR_STAT = BASE_ADDR + CON_STATUS;

  logic          hit_data_s, hit_exit_s, hit_stat_s;
  logic          wr_data_s, wr_exit_s, wr_stat_s;
  logic [15:0]   code_r;
  logic          done_r, pass_r, overflow_r;
  logic [7:0]    fifo_dout_s;
  logic          fifo_full_s, fifo_empty_s, pop_s;
  logic [CW-1:0] fifo_count_s;
  logic [3:0]    count4_s;
  logic [31:0]   status_s;

  con_tx_state_t state_r;
  logic [BW-1:0] baud_r;
  logic [2:0]    bit_r;
  logic [7:0]    shift_r;
  logic          tx_r;
  logic          baud_end_s;
  logic          tx_busy_s;

  assign hit_data_s = (addr == ADDR_DATA);
  assign hit_exit_s = (addr == ADDR_EXIT);
  assign hit_stat_s = (addr == ADDR_STAT);
  assign sel        = hit_data_s || hit_exit_s || hit_stat_s;
  assign wr_data_s  = memwrite && hit_data_s;
  assign wr_exit_s  = memwrite && hit_exit_s;
  assign wr_stat_s  = memwrite && hit_stat_s;

  assign baud_end_s = (baud_r == BAUD_MAX);
  assign tx_busy_s  = (state_r != TX_IDLE);
  assign count4_s   = 4'(fifo_count_s);

  assign tx   = tx_r;
  assign done = done_r;
  assign pass = pass_r;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_data_s),
    .din   (wd[7:0]),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Exit code capture; pass is registered alongside so it is valid with done
  always_ff @(posedge clk) begin
    if (reset) begin
      code_r <= 16'd0;
      done_r <= 1'b0;
      pass_r <= 1'b0;
    end else if (wr_exit_s) begin
      code_r <= wd;
      done_r <= 1'b1;
      pass_r <= (wd == PASS_CODE);
    end
  end

  // Sticky overflow: set by a dropped character, cleared by a STATUS store
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (wr_data_s && fifo_full_s) begin
      overflow_r <= 1'b1;
    end else if (wr_stat_s && wd[ST_CLR_OVF]) begin
      overflow_r <= 1'b0;
    end
  end

  // STATUS word assembly
  always_comb begin
    status_s                      = 32'd0;
    status_s[ST_DONE]             = done_r;
    status_s[ST_PASS]             = pass_r;
    status_s[ST_BUSY]             = tx_busy_s;
    status_s[ST_EMPTY]            = fifo_empty_s;
    status_s[ST_FULL]             = fifo_full_s;
    status_s[ST_OVERFLOW]         = overflow_r;
    status_s[ST_COUNT_LSB +: 4]   = count4_s;
  end

  // Read mux; DATA and unselected addresses read as zero
  always_comb begin
    rd = 32'd0;
    if (hit_exit_s) begin
      rd = {16'd0, code_r};
    end else if (hit_stat_s) begin
      rd = status_s;
    end else begin
      rd = 32'd0;
    end
  end

  // FIFO pop request: from IDLE, or at the last STOP cycle for gapless frames
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      TX_IDLE: pop_s = !fifo_empty_s;
      TX_STOP: pop_s = baud_end_s && !fifo_empty_s;
      default: pop_s = 1'b0;
    endcase
  end

  // 8N1 transmitter; tx is registered and changes on the state transitions
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= TX_IDLE;
      baud_r  <= BW'(0);
      bit_r   <= 3'd0;
      shift_r <= 8'd0;
      tx_r    <= 1'b1;
    end else begin
      case (state_r)
        TX_IDLE: begin
          baud_r <= BW'(0);
          if (pop_s) begin
            shift_r <= fifo_dout_s;
            bit_r   <= 3'd0;
            state_r <= TX_START;
            tx_r    <= 1'b0;
          end else begin
            tx_r    <= 1'b1;
          end
        end
        TX_START: begin
          if (baud_end_s) begin
            baud_r  <= BW'(0);
            state_r <= TX_DATA;
            tx_r    <= shift_r[0];
          end else begin
            baud_r  <= baud_r + BW'(1);
          end
        end
        TX_DATA: begin
          if (baud_end_s) begin
            baud_r <= BW'(0);
            if (bit_r == 3'd7) begin
              state_r <= TX_STOP;
              tx_r    <= 1'b1;
            end else begin
              bit_r   <= bit_r + 3'd1;
              shift_r <= {1'b0, shift_r[7:1]};
              tx_r    <= shift_r[1];
            end
          end else begin
            baud_r <= baud_r + BW'(1);
          end
        end
        TX_STOP: begin
          if (baud_end_s) begin
            baud_r <= BW'(0);
            if (pop_s) begin
              shift_r <= fifo_dout_s;
              bit_r   <= 3'd0;
              state_r <= TX_START;
              tx_r    <= 1'b0;
            end else begin
              state_r <= TX_IDLE;
              tx_r    <= 1'b1;
            end
          end else begin
            baud_r <= baud_r + BW'(1);
          end
        end
        default: begin
          state_r <= TX_IDLE;
          baud_r  <= BW'(0);
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ktc16_console.sv
// Directed bench for ktc16_console with CLKS_PER_BIT=4, FIFO_DEPTH=8.
module tb_ktc16_console;

  localparam logic [15:0] BASE = 16'd80;
  localparam logic [15:0] A_DATA = 16'd80;
  localparam logic [15:0] A_EXIT = 16'd84;
  localparam logic [15:0] A_STAT = 16'd88;
  localparam int CPB = 4;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [15:0] addr;
  logic [15:0] wd;
  logic [31:0] rd;
  logic        sel;
  logic        tx;
  logic        done;
  logic        pass;

  int tests_run;
  int tests_failed;

  ktc16_console #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (8),
    .PASS_CODE    (16'd7)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .memwrite (memwrite),
    .addr     (addr),
    .wd       (wd),
    .rd       (rd),
    .sel      (sel),
    .tx       (tx),
    .done     (done),
    .pass     (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One store captured on the next rising edge; returns on the following negedge
  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    memwrite = 1'b1;
    addr     = a;
    wd       = d;
    @(negedge clk);
    memwrite = 1'b0;
  endtask

  // Combinational read at the current time
  task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rd;
  endtask

  // Expected line level at sample i (0 = first cycle after the pop edge)
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    logic r;
    if (i < CPB) r = 1'b0;
    else if (i < 9 * CPB) r = b[(i - CPB) / CPB];
    else r = 1'b1;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    tests_run++;
    if (tx !== 1'b1 || done !== 1'b0 || pass !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: tx=%b done=%b pass=%b, want 1 0 0", tx, done, pass);
    end
    bus_read(A_STAT, v);
    tests_run++;
    if (v !== 32'h0000_0008) begin
      tests_failed++;
      $display("FAIL reset_status: got %h want 00000008", v);
    end
    bus_read(A_EXIT, v);
    tests_run++;
    if (v !== 32'd0 || sel !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_exit: got %h sel=%b want 00000000 sel=1", v, sel);
    end
    bus_read(A_DATA, v);
    tests_run++;
    if (v !== 32'd0 || sel !== 1'b1) begin
      tests_failed++;
      $display("FAIL data_read: got %h sel=%b want 00000000 sel=1", v, sel);
    end
    bus_read(16'd82, v);
    tests_run++;
    if (v !== 32'd0 || sel !== 1'b0) begin
      tests_failed++;
      $display("FAIL unmapped_read: got %h sel=%b want 00000000 sel=0", v, sel);
    end
  endtask

  task automatic test_single_frame();
    logic [31:0] v;
    int bad;
    bus_write(A_DATA, 16'h0041);
    tests_run++;
    if (tx !== 1'b1) begin
      tests_failed++;
      $display("FAIL frame_pre_start: tx=%b want 1", tx);
    end
    bad = 0;
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk);
      tests_run++;
      if (tx !== frame_bit(8'h41, i)) begin
        tests_failed++;
        bad++;
        if (bad < 4) $display("FAIL frame_41 sample %0d: tx=%b want %b", i, tx, frame_bit(8'h41, i));
      end
    end
    bus_read(A_STAT, v);
    tests_run++;
    if (v[2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_last_stop: busy=%b want 1", v[2]);
    end
    @(negedge clk);
    bus_read(A_STAT, v);
    tests_run++;
    if (v[2] !== 1'b0 || tx !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_after_frame: busy=%b tx=%b want 0 1", v[2], tx);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    logic [7:0] bytes [3];
    int bad;
    bytes[0] = 8'h31;
    bytes[1] = 8'h32;
    bytes[2] = 8'h33;
    @(negedge clk);
    memwrite = 1'b1;
    addr = A_DATA;
    wd = 16'h0031;
    @(negedge clk);
    wd = 16'h0032;
    @(negedge clk);
    wd = 16'h0033;
    @(negedge clk);
    memwrite = 1'b0;
    bus_read(A_STAT, v);
    tests_run++;
    if (v[11:8] !== 4'd2) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d want 2", v[11:8]);
    end
    bad = 0;
    for (int i = 1; i < 30 * CPB; i++) begin
      if (i > 1) @(negedge clk);
      tests_run++;
      if (tx !== frame_bit(bytes[i / (10 * CPB)], i % (10 * CPB))) begin
        tests_failed++;
        bad++;
        if (bad < 4) $display("FAIL b2b sample %0d: tx=%b want %b", i, tx,
                              frame_bit(bytes[i / (10 * CPB)], i % (10 * CPB)));
      end
    end
    @(negedge clk);
    bus_read(A_STAT, v);
    tests_run++;
    if (v[2] !== 1'b0 || v[3] !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_end: busy=%b empty=%b want 0 1", v[2], v[3]);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    bus_write(A_DATA, 16'h0050);
    @(negedge clk);
    for (int k = 0; k < 8; k++) bus_write(A_DATA, 16'h0060 + 16'(k));
    bus_read(A_STAT, v);
    tests_run++;
    if (v[4] !== 1'b1 || v[5] !== 1'b0 || v[11:8] !== 4'd8) begin
      tests_failed++;
      $display("FAIL fill: full=%b ovf=%b count=%0d want 1 0 8", v[4], v[5], v[11:8]);
    end
    bus_write(A_DATA, 16'h0070);
    bus_read(A_STAT, v);
    tests_run++;
    if (v[4] !== 1'b1 || v[5] !== 1'b1 || v[11:8] !== 4'd8 || v[2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow: full=%b ovf=%b count=%0d busy=%b want 1 1 8 1", v[4], v[5], v[11:8], v[2]);
    end
    bus_write(A_STAT, 16'h0020);
    bus_read(A_STAT, v);
    tests_run++;
    if (v[5] !== 1'b0 || v[4] !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_clear: ovf=%b full=%b want 0 1", v[5], v[4]);
    end
  endtask

  task automatic test_exit();
    logic [31:0] v;
    do_reset();
    bus_write(A_EXIT, 16'd7);
    bus_read(A_EXIT, v);
    tests_run++;
    if (done !== 1'b1 || pass !== 1'b1 || v !== 32'h0000_0007) begin
      tests_failed++;
      $display("FAIL exit7: done=%b pass=%b rd=%h want 1 1 00000007", done, pass, v);
    end
    do_reset();
    bus_write(A_EXIT, 16'd5);
    bus_read(A_STAT, v);
    tests_run++;
    if (done !== 1'b1 || pass !== 1'b0 || v[1:0] !== 2'b01) begin
      tests_failed++;
      $display("FAIL exit5: done=%b pass=%b st=%b want 1 0 01", done, pass, v[1:0]);
    end
    bus_read(A_EXIT, v);
    tests_run++;
    if (v !== 32'h0000_0005) begin
      tests_failed++;
      $display("FAIL exit5_read: got %h want 00000005", v);
    end
    bus_write(A_EXIT, 16'd7);
    bus_read(A_STAT, v);
    tests_run++;
    if (done !== 1'b1 || pass !== 1'b1 || v[1:0] !== 2'b11) begin
      tests_failed++;
      $display("FAIL exit5then7: done=%b pass=%b st=%b want 1 1 11", done, pass, v[1:0]);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] v;
    int bad;
    do_reset();
    bus_write(A_DATA, 16'h00A5);
    bus_write(A_DATA, 16'h005A);
    // First write's edge is N; now just after N+2. Bit 3 spans samples 16..19.
    for (int i = 0; i < 16; i++) @(negedge clk);
    tests_run++;
    if (tx !== 1'b0) begin
      tests_failed++;
      $display("FAIL midframe_bit3: tx=%b want 0", tx);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus_read(A_STAT, v);
    tests_run++;
    if (tx !== 1'b1 || v[11:8] !== 4'd0 || v[2] !== 1'b0 || v[3] !== 1'b1) begin
      tests_failed++;
      $display("FAIL midframe_reset: tx=%b count=%0d busy=%b empty=%b want 1 0 0 1",
               tx, v[11:8], v[2], v[3]);
    end
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL no_residual: %0d low samples, want 0", bad);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset    = 1'b1;
    memwrite = 1'b0;
    addr     = 16'd0;
    wd       = 16'd0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_exit();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
